// File: rtl/fetchbuffer_sched.sv
// fetchbuffer_sched: arbitrates demand vs next-line prefetch line requests to the I$ (optional FB_PREFETCH_PREEMPT_EN lets demand preempt a prefetch)
module fetchbuffer_sched #(
  parameter int PA_BITS  = 56,
  parameter int LINE_OFF = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               DemandReq,
  input  logic [PA_BITS-1:0] DemandPAdr,
  input  logic               PrefetchReq,
  input  logic [PA_BITS-1:0] PrefetchPAdr,
  input  logic               Stall,
  input  logic               Flush,
  input  logic               CacheReady,
  input  logic               CacheDone,
  output logic               CacheReq,
  output logic [PA_BITS-1:0] CachePAdr,
  output logic               CacheAbort,
  output logic               DemandGrant,
  output logic               PrefetchGrant,
  output logic               DemandDone,
  output logic               PrefetchDone,
  output logic               PrefetchDrop,
  output logic               Busy
);
  typedef enum logic [2:0] {IDLE, REQ_D, WAIT_D, REQ_P, WAIT_P} state_t;
  localparam logic [PA_BITS-1:0] LINE_MASK = {{(PA_BITS-LINE_OFF){1'b1}}, {LINE_OFF{1'b0}}};
  state_t state, state_n;
  logic [PA_BITS-1:0] req_adr, last_line, d_line, p_line;
  logic last_valid, idle, in_req, in_wait, live, go, idle_drop, done, preempt;
  // request decode: grants, drops, completion and preemption for this cycle
  always_comb begin
    d_line    = DemandPAdr & LINE_MASK;
    p_line    = PrefetchPAdr & LINE_MASK;
    idle      = state == IDLE;
    in_req    = state == REQ_D || state == REQ_P;
    in_wait   = state == WAIT_D || state == WAIT_P;
    live      = !reset && !Flush;
    go        = idle && live && !Stall;
    idle_drop = go && PrefetchReq && ((last_valid && p_line == last_line) || (DemandReq && p_line == d_line));
    done      = in_wait && CacheDone && live;
`ifdef FB_PREFETCH_PREEMPT_EN
    preempt   = live && DemandReq && (state == REQ_P || (state == WAIT_P && !CacheDone));
`else
    preempt   = 1'b0;
`endif
  end
  assign DemandGrant   = go && DemandReq;
  assign PrefetchGrant = go && PrefetchReq && !DemandReq && !idle_drop;
  assign PrefetchDrop  = idle_drop || preempt;
  assign DemandDone    = done && state == WAIT_D;
  assign PrefetchDone  = done && state == WAIT_P;
  assign CacheAbort    = !reset && in_wait && (Flush || preempt);
  assign CacheReq      = !reset && in_req;
  assign CachePAdr     = CacheReq ? req_adr : '0;
  assign Busy          = !reset && !idle;
  // next-state selection; flush and preemption always return to IDLE
  always_comb begin
    state_n = (Flush || preempt) ? IDLE :
              DemandGrant ? REQ_D :
              PrefetchGrant ? REQ_P :
              (in_req && CacheReady) ? (state == REQ_D ? WAIT_D : WAIT_P) :
              (in_wait && CacheDone) ? IDLE : state;
  end
  // state, captured line address and last-completed-line tracking
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      req_adr    <= '0;
      last_line  <= '0;
      last_valid <= 1'b0;
    end else begin
      state <= state_n;
      if (DemandGrant) req_adr <= d_line;
      else if (PrefetchGrant) req_adr <= p_line;
      if (done) begin
        last_line  <= req_adr;
        last_valid <= 1'b1;
      end
      if (Flush) last_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_fetchbuffer_sched.sv
// tb_fetchbuffer_sched: directed plan steps plus randomized traffic against a transaction-level model
module tb_fetchbuffer_sched;
  logic clk = 0, reset = 1;
  logic DemandReq = 0, PrefetchReq = 0, Stall = 0, Flush = 0, CacheReady = 0, CacheDone = 0;
  logic [55:0] DemandPAdr = 0, PrefetchPAdr = 0;
  logic CacheReq, CacheAbort, DemandGrant, PrefetchGrant, DemandDone, PrefetchDone, PrefetchDrop, Busy;
  logic [55:0] CachePAdr;
  int n_checks = 0, n_err = 0;
`ifdef FB_PREFETCH_PREEMPT_EN
  localparam bit PREEMPT = 1;
`else
  localparam bit PREEMPT = 0;
`endif

  fetchbuffer_sched dut (
    .clk(clk), .reset(reset), .DemandReq(DemandReq), .DemandPAdr(DemandPAdr),
    .PrefetchReq(PrefetchReq), .PrefetchPAdr(PrefetchPAdr), .Stall(Stall), .Flush(Flush),
    .CacheReady(CacheReady), .CacheDone(CacheDone), .CacheReq(CacheReq), .CachePAdr(CachePAdr),
    .CacheAbort(CacheAbort), .DemandGrant(DemandGrant), .PrefetchGrant(PrefetchGrant),
    .DemandDone(DemandDone), .PrefetchDone(PrefetchDone), .PrefetchDrop(PrefetchDrop), .Busy(Busy)
  );

  always #5 clk = ~clk;

  // Model: one outstanding transaction (kind, line number, accepted?) plus the last completed line
  bit m_busy, m_kind, m_acc, m_lv, n_busy, n_kind, n_acc, n_lv;
  logic [55:0] m_line, m_last, n_line, n_last;
  bit e_req, e_abort, e_dg, e_pg, e_dd, e_pd, e_drop, e_busy;
  logic [55:0] e_adr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic eval();
    logic [55:0] dl, pl;
    bit go, pre;
    #2;
    dl = DemandPAdr >> 6;
    pl = PrefetchPAdr >> 6;
    {e_req, e_abort, e_dg, e_pg, e_dd, e_pd, e_drop} = '0;
    {n_busy, n_kind, n_acc, n_lv, n_line, n_last} = {m_busy, m_kind, m_acc, m_lv, m_line, m_last};
    if (reset) begin
      {n_busy, n_kind, n_acc, n_lv} = '0;
    end else if (!m_busy) begin
      go = !Stall && !Flush;
      e_drop = go && PrefetchReq && ((m_lv && pl == m_last) || (DemandReq && pl == dl));
      e_dg = go && DemandReq;
      e_pg = go && PrefetchReq && !DemandReq && !e_drop;
      if (e_dg || e_pg) {n_busy, n_kind, n_acc, n_line} = {1'b1, e_pg, 1'b0, e_dg ? dl : pl};
    end else begin
      pre = PREEMPT && m_kind && DemandReq && !Flush;
      if (!m_acc) begin
        e_req = 1;
        if (Flush) n_busy = 0;
        else if (pre) begin e_drop = 1; n_busy = 0; end
        else if (CacheReady) n_acc = 1;
      end else if (Flush) begin
        e_abort = 1; n_busy = 0;
      end else if (CacheDone) begin
        e_dd = !m_kind; e_pd = m_kind; n_busy = 0; n_last = m_line; n_lv = 1;
      end else if (pre) begin
        e_abort = 1; e_drop = 1; n_busy = 0;
      end
    end
    if (Flush) n_lv = 0;
    e_busy = !reset && m_busy;
    e_adr = e_req ? m_line << 6 : 56'h0;
    chk("CacheReq", CacheReq, e_req);
    chk("CachePAdr", CachePAdr, e_adr);
    chk("CacheAbort", CacheAbort, e_abort);
    chk("DemandGrant", DemandGrant, e_dg);
    chk("PrefetchGrant", PrefetchGrant, e_pg);
    chk("DemandDone", DemandDone, e_dd);
    chk("PrefetchDone", PrefetchDone, e_pd);
    chk("PrefetchDrop", PrefetchDrop, e_drop);
    chk("Busy", Busy, e_busy);
  endtask

  task automatic adv();
    @(posedge clk);
    {m_busy, m_kind, m_acc, m_lv, m_line, m_last} = {n_busy, n_kind, n_acc, n_lv, n_line, n_last};
    #1;
  endtask

  function automatic logic [55:0] rand_adr();
    return 56'h1000 + 56'($urandom_range(0, 3)) * 56'h40 + 56'($urandom_range(0, 63));
  endfunction

  initial begin
    bit dpend, ppend;
    {m_busy, m_kind, m_acc, m_lv, m_line, m_last} = '0;
    // reset: all outputs low
    #1; eval();
    chk("rst_req", CacheReq, 0); chk("rst_adr", CachePAdr, 0); chk("rst_busy", Busy, 0);
    adv(); eval(); adv();
    reset = 0; CacheReady = 1;
    // demand 0x8000_0044: grant t, req t+1 aligned, done t+3
    DemandReq = 1; DemandPAdr = 56'h8000_0044;
    eval(); chk("d1_grant", DemandGrant, 1); adv(); DemandReq = 0;
    eval(); chk("d1_req", CacheReq, 1); chk("d1_adr", CachePAdr, 56'h8000_0040); adv();
    eval(); adv();
    CacheDone = 1; eval(); chk("d1_done", DemandDone, 1); adv(); CacheDone = 0;
    eval(); chk("d1_idle", Busy, 0); adv();
    // simultaneous demand 0x1000 / prefetch 0x1040
    DemandReq = 1; DemandPAdr = 56'h1000; PrefetchReq = 1; PrefetchPAdr = 56'h1040;
    eval(); chk("d2_dg", DemandGrant, 1); chk("d2_pg", PrefetchGrant, 0); adv(); DemandReq = 0;
    eval(); adv();
    CacheDone = 1; eval(); chk("d2_done", DemandDone, 1); chk("d2_pg_wait", PrefetchGrant, 0); adv(); CacheDone = 0;
    eval(); chk("d2_pg", PrefetchGrant, 1); adv(); PrefetchReq = 0;
    eval(); chk("d2_padr", CachePAdr, 56'h1040); adv();
    CacheDone = 1; eval(); chk("d2_pdone", PrefetchDone, 1); adv(); CacheDone = 0;
    // prefetch of just-completed line 0x2000 is dropped
    DemandReq = 1; DemandPAdr = 56'h2000; eval(); adv(); DemandReq = 0;
    eval(); adv(); CacheDone = 1; eval(); adv(); CacheDone = 0;
    PrefetchReq = 1; PrefetchPAdr = 56'h2000;
    eval(); chk("d3_drop", PrefetchDrop, 1); chk("d3_pg", PrefetchGrant, 0); adv(); PrefetchReq = 0;
    eval(); chk("d3_noreq", CacheReq, 0); adv();
    // flush with coincident CacheDone in WAIT_D
    DemandReq = 1; DemandPAdr = 56'h3000; eval(); adv(); DemandReq = 0;
    eval(); adv();
    Flush = 1; CacheDone = 1;
    eval(); chk("d4_abort", CacheAbort, 1); chk("d4_done", DemandDone, 0); adv(); Flush = 0; CacheDone = 0;
    eval(); chk("d4_busy", Busy, 0); adv();
    // demand during WAIT_P
    PrefetchReq = 1; PrefetchPAdr = 56'h4000; eval(); adv(); PrefetchReq = 0;
    eval(); adv();
    DemandReq = 1; DemandPAdr = 56'h5000;
    if (PREEMPT) begin
      eval(); chk("d5_abort", CacheAbort, 1); chk("d5_drop", PrefetchDrop, 1); adv();
    end else begin
      eval(); chk("d5_nogrant", DemandGrant, 0); adv();
      CacheDone = 1; eval(); chk("d5_pdone", PrefetchDone, 1); adv(); CacheDone = 0;
    end
    eval(); chk("d5_grant", DemandGrant, 1); adv(); DemandReq = 0;
    eval(); adv(); CacheDone = 1; eval(); adv(); CacheDone = 0;
    // CacheReady low 5 cycles in REQ_D with Stall toggling and a prefetch pending
    CacheReady = 0; DemandReq = 1; DemandPAdr = 56'h6010; eval(); adv(); DemandReq = 0;
    PrefetchReq = 1; PrefetchPAdr = 56'h7000;
    for (int i = 0; i < 5; i++) begin
      Stall = i[0];
      eval(); chk("d6_req", CacheReq, 1); chk("d6_adr", CachePAdr, 56'h6000);
      chk("d6_dg", DemandGrant, 0); chk("d6_pg", PrefetchGrant, 0); adv();
    end
    Stall = 0; CacheReady = 1; eval(); adv();
    CacheDone = 1; eval(); adv(); CacheDone = 0;
    eval(); chk("d6_pg_after", PrefetchGrant, 1); adv(); PrefetchReq = 0;
    eval(); adv(); CacheDone = 1; eval(); adv(); CacheDone = 0;
    // reset mid-request: no abort, immediately idle
    DemandReq = 1; DemandPAdr = 56'h9000; eval(); adv(); DemandReq = 0;
    eval(); adv();
    reset = 1; eval(); chk("d7_abort", CacheAbort, 0); chk("d7_busy", Busy, 0); adv(); reset = 0;
    eval(); chk("d7_idle", Busy, 0); adv();
    // randomized traffic obeying the request/hold protocol
    dpend = 0; ppend = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!dpend && $urandom_range(0, 5) == 0) begin dpend = 1; DemandPAdr = rand_adr(); end
      if (!ppend && $urandom_range(0, 3) == 0) begin ppend = 1; PrefetchPAdr = rand_adr(); end
      DemandReq = dpend; PrefetchReq = ppend;
      Stall = $urandom_range(0, 3) == 0;
      Flush = $urandom_range(0, 19) == 0;
      CacheReady = $urandom_range(0, 1) == 1;
      CacheDone = m_busy && m_acc && $urandom_range(0, 2) == 0;
      eval();
      if (e_dg) dpend = 0;
      if (e_pg || (e_drop && !m_busy)) ppend = 0;
      adv();
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/fetchbuffer_sched.md
# fetchbuffer_sched

Request scheduler between the IFU fetch buffer and the instruction cache read port. It arbitrates demand line fetches (fetch-buffer miss on PCF) against next-line prefetches (fetch buffer nearing end of active line). It issues one line request at a time to the cache, tracks it to completion, and cancels it on pipeline flush. It sits between the fetch buffer's line-enable logic and the I$ request interface.

## Interface
- PA_BITS, 56, physical address width
- LINE_OFF, 6, log2 of line size in bytes (64-byte lines)
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- DemandReq  in  1  fetch buffer needs line for PCF; held until DemandGrant
- DemandPAdr  in  PA_BITS  demand byte address
- PrefetchReq  in  1  fetch buffer requests next line; held until PrefetchGrant or PrefetchDrop
- PrefetchPAdr  in  PA_BITS  prefetch byte address
- Stall  in  1  pipeline stall; blocks new grants only
- Flush  in  1  pipeline flush; cancels all activity
- CacheReady  in  1  cache accepts request this cycle
- CacheDone  in  1  one-cycle pulse, line on ReadDataLine valid
- CacheReq  out  1  request valid to cache
- CachePAdr  out  PA_BITS  line-aligned request address (low LINE_OFF bits zero)
- CacheAbort  out  1  one-cycle cancel of accepted, unfinished request
- DemandGrant, PrefetchGrant  out  1  one-cycle pulse on request capture
- DemandDone, PrefetchDone  out  1  one-cycle pulse; fetch buffer writes line
- PrefetchDrop  out  1  one-cycle pulse; prefetch discarded, not issued
- Busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, REQ_D, WAIT_D, REQ_P, WAIT_P.
- IDLE, ~Stall, ~Flush: DemandReq wins. It captures the line address into ReqAdr, pulses DemandGrant, and moves to REQ_D. Otherwise a PrefetchReq is handled as follows:
  - If its line equals LastLine (valid) or equals DemandPAdr's line while DemandReq is high, it is dropped: PrefetchDrop pulses and the state stays IDLE.
  - Otherwise it captures the address, pulses PrefetchGrant, and moves to REQ_P.
- REQ_x: CacheReq=1, CachePAdr=ReqAdr. CacheReady=1 moves to WAIT_x.
- WAIT_x: CacheDone moves to IDLE and pulses xDone the same cycle (combinational). LastLine←ReqAdr and LastLineValid←1.
- Flush in any state: next state IDLE. In WAIT_x, CacheAbort=Flush (same cycle), and xDone is suppressed even if CacheDone coincides. In REQ_x, CacheReq is withdrawn next cycle. LastLineValid is cleared.
- The cache guarantees no CacheDone after CacheAbort.
- Grants are never issued in the cycle Flush or Stall is high. Stall does not affect REQ_x/WAIT_x progress.
- The line compare uses bits [PA_BITS-1:LINE_OFF] only.

## Timing
- Reset: state IDLE, ReqAdr=0, LastLineValid=0. All outputs 0; CachePAdr=0.
- Grant to CacheReq: 1 cycle. With CacheReady tied high, grant is at t, CacheReq at t+1, WAIT at t+2.
- CacheDone to xDone: 0 cycles. IDLE is re-entered at the next edge, so the next grant can occur the cycle after done.
- DemandReq and PrefetchReq in the same IDLE cycle: demand granted. The prefetch stays pending, or is dropped if it matches the demand line.
- Reset mid-request: immediate return to IDLE. No CacheAbort is generated; the cache is reset by the same signal.
- Flush and CacheDone in the same WAIT cycle: CacheAbort=1, xDone=0, LastLine not updated.

## Configuration
- FB_PREFETCH_PREEMPT_EN defined: DemandReq arriving in REQ_P or WAIT_P (no Flush) preempts the prefetch.
  - WAIT_P: CacheAbort pulses. REQ_P: CacheReq drops.
  - PrefetchDrop pulses and the state goes to IDLE. The demand is granted the following cycle.
  - If CacheDone coincides in WAIT_P, the prefetch completes normally (PrefetchDone) and no abort occurs.
- Undefined: demand waits until the prefetch completes. Worst-case demand latency is prefetch latency plus 1.

## Test plan
- Demand 0x8000_0044, CacheReady=1, CacheDone at t+3 → DemandGrant t, CacheReq t+1 with CachePAdr 0x8000_0040, DemandDone t+3.
- Simultaneous DemandReq 0x1000 and PrefetchReq 0x1040 → demand granted first; prefetch granted the cycle after DemandDone; CachePAdr 0x1040.
- Prefetch 0x2000 after a completed fetch of line 0x2000 → PrefetchDrop pulse, no CacheReq.
- Flush in WAIT_D with simultaneous CacheDone → CacheAbort=1, DemandDone=0, Busy=0 next cycle.
- Macro on: DemandReq during WAIT_P → CacheAbort and PrefetchDrop same cycle, DemandGrant next cycle. Macro off → DemandGrant the cycle after PrefetchDone.
- CacheReady held low 5 cycles in REQ_D with Stall toggling → CacheReq and CachePAdr stable throughout; no extra grants.
